// File: rtl/perf_counter.sv
// Eight-entry commit-event counter bank with a 32-bit coherent read port
// (low read captures the upper word into a snapshot), clear, freeze and overflow IRQ.
module perf_counter #(
    parameter int CNT_WD = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        real_valid,
    input  logic        real_br_inst,
    input  logic        real_br_pre,
    input  logic        real_br_pre_error,
    input  logic        real_icache_miss,
    input  logic        real_dcache_miss,
    input  logic        real_mem_inst,
    input  logic        freeze,
    input  logic        clr_en,
    input  logic [7:0]  clr_mask,
    input  logic [7:0]  irq_mask,
    input  logic        rd_en,
    input  logic [2:0]  rd_sel,
    input  logic        rd_hi,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [7:0]  ovf,
    output logic        ovf_irq
);
    localparam int HI_WD = CNT_WD - 32;

    logic [7:0]        ev;
    logic [7:0]        ovf_vec;
    logic [CNT_WD-1:0] cnt_vec [8];

    // Slot 0 counts cycles; events are deliberately not qualified by real_valid.
    assign ev = {real_mem_inst, real_dcache_miss, real_icache_miss, real_br_pre_error,
                 real_br_pre, real_br_inst, real_valid, 1'b1};

    for (genvar i = 0; i < 8; i++) begin : g_cnt
        logic [CNT_WD-1:0] cnt_q, cnt_d;
        logic              ovf_q, ovf_d;

        always_comb begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
            if (clr_en && clr_mask[i]) begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (!freeze && ev[i]) begin
                cnt_d = cnt_q + CNT_WD'(1);
                if (&cnt_q) ovf_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end
        end

        assign cnt_vec[i] = cnt_q;
        assign ovf_vec[i] = ovf_q;
    end

    logic [31:0]      rd_data_q, rd_data_d;
    logic [HI_WD-1:0] snap_q, snap_d;
    logic             rd_valid_q;

    // Reads sample pre-update counter values, so a same-cycle clear returns the old count.
    always_comb begin
        rd_data_d = rd_data_q;
        snap_d    = snap_q;
        if (rd_en) begin
            if (rd_hi) begin
                rd_data_d = 32'(snap_q);
            end else begin
                rd_data_d = cnt_vec[rd_sel][31:0];
                snap_d    = cnt_vec[rd_sel][CNT_WD-1:32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            snap_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            snap_q     <= snap_d;
            rd_valid_q <= rd_en;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ovf      = ovf_vec;
    assign ovf_irq  = |(ovf_vec & irq_mask);
endmodule

// File: tb/tb_perf_counter.sv
// Randomized + directed bench for perf_counter against a per-cycle arithmetic model.
module tb_perf_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        real_valid = 0, real_br_inst = 0, real_br_pre = 0, real_br_pre_error = 0;
    logic        real_icache_miss = 0, real_dcache_miss = 0, real_mem_inst = 0;
    logic        freeze = 0, clr_en = 0, rd_en = 0, rd_hi = 0;
    logic [7:0]  clr_mask = 0, irq_mask = 0;
    logic [2:0]  rd_sel = 0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [7:0]  ovf;
    logic        ovf_irq;

    perf_counter #(.CNT_WD(64)) dut (
        .clk(clk), .reset(reset),
        .real_valid(real_valid), .real_br_inst(real_br_inst), .real_br_pre(real_br_pre),
        .real_br_pre_error(real_br_pre_error), .real_icache_miss(real_icache_miss),
        .real_dcache_miss(real_dcache_miss), .real_mem_inst(real_mem_inst),
        .freeze(freeze), .clr_en(clr_en), .clr_mask(clr_mask), .irq_mask(irq_mask),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_hi(rd_hi),
        .rd_data(rd_data), .rd_valid(rd_valid), .ovf(ovf), .ovf_irq(ovf_irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    logic [63:0] m_cnt [8];
    logic [7:0]  m_ovf;
    logic [31:0] m_snap;
    logic [31:0] exp_rd;
    logic        exp_rv;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_cnt[i] = '0;
        m_ovf = '0; m_snap = '0; exp_rd = '0; exp_rv = 1'b0;
    endtask

    // One clock: model advances on the posedge using the inputs held since the last negedge,
    // outputs are compared on the following negedge.
    task automatic tick();
        logic [7:0] ev;
        @(posedge clk);
        ev = {real_mem_inst, real_dcache_miss, real_icache_miss, real_br_pre_error,
              real_br_pre, real_br_inst, real_valid, 1'b1};
        exp_rv = rd_en;
        if (rd_en) begin
            if (rd_hi) exp_rd = m_snap;
            else begin
                exp_rd = m_cnt[rd_sel][31:0];
                m_snap = m_cnt[rd_sel][63:32];
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (clr_en && clr_mask[i]) begin
                m_cnt[i] = '0;
                m_ovf[i] = 1'b0;
            end else if (!freeze && ev[i]) begin
                if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf[i] = 1'b1;
                m_cnt[i] = m_cnt[i] + 64'd1;
            end
        end
        @(negedge clk);
        chk("rd_valid", rd_valid, exp_rv);
        chk("rd_data", rd_data, exp_rd);
        chk("ovf", ovf, m_ovf);
        chk("ovf_irq", ovf_irq, |(m_ovf & irq_mask));
    endtask

    task automatic rd(input logic [2:0] sel, input logic hi);
        rd_en = 1'b1; rd_sel = sel; rd_hi = hi;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic set_events(input logic [6:0] e);
        {real_mem_inst, real_dcache_miss, real_icache_miss, real_br_pre_error,
         real_br_pre, real_br_inst, real_valid} = e;
    endtask

    logic [63:0] saved [8];
    logic [63:0] old1;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ovf_irq", ovf_irq, 0);
        reset = 1'b1;

        // Idle: 10 counted cycles, the read issue cycle samples the pre-update value 10.
        repeat (10) tick();
        rd(3'd0, 1'b0);
        chk("cnt0_idle", rd_data, 10);
        for (int i = 1; i < 8; i++) begin
            rd(3'(i), 1'b0);
            chk("cntN_idle", rd_data, 0);
        end

        // real_valid x5, br_inst x2
        for (int c = 0; c < 5; c++) begin
            real_valid = 1'b1;
            real_br_inst = (c < 2);
            tick();
        end
        set_events('0);
        rd(3'd1, 1'b0); chk("cnt1_five", rd_data, 5);
        rd(3'd2, 1'b0); chk("cnt2_two", rd_data, 2);
        chk("ovf_none", ovf, 0);

        // Overflow of dcache counter
        irq_mask = 8'h40;
        force dut.g_cnt[6].cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.g_cnt[6].cnt_q;
        m_cnt[6] = 64'hFFFF_FFFF_FFFF_FFFF;
        real_dcache_miss = 1'b1;
        tick();
        real_dcache_miss = 1'b0;
        chk("ovf6_set", ovf[6], 1);
        chk("ovf6_irq", ovf_irq, 1);
        rd(3'd6, 1'b0); chk("cnt6_wrap_lo", rd_data, 0);
        rd(3'd6, 1'b1); chk("cnt6_wrap_hi", rd_data, 0);
        clr_en = 1'b1; clr_mask = 8'h40;
        tick();
        clr_en = 1'b0; clr_mask = 8'h00;
        chk("ovf6_clr", ovf[6], 0);
        chk("irq_clr", ovf_irq, 0);

        // Coherent 64-bit read across a carry into the high word
        force dut.g_cnt[1].cnt_q = 64'h1_FFFF_FFFF;
        #1 release dut.g_cnt[1].cnt_q;
        m_cnt[1] = 64'h1_FFFF_FFFF;
        real_valid = 1'b1;
        rd(3'd1, 1'b0); chk("snap_lo", rd_data, 32'hFFFF_FFFF);
        real_valid = 1'b0;
        rd(3'd1, 1'b1); chk("snap_hi", rd_data, 1);
        rd(3'd1, 1'b0); chk("after_carry_lo", rd_data, 0);
        rd(3'd1, 1'b1); chk("after_carry_hi", rd_data, 2);

        // Clear vs same-cycle increment and read
        old1 = m_cnt[1];
        real_valid = 1'b1; clr_en = 1'b1; clr_mask = 8'h02;
        rd(3'd1, 1'b0); chk("clr_rd_old", rd_data, old1[31:0]);
        real_valid = 1'b0; clr_en = 1'b0; clr_mask = 8'h00;
        rd(3'd1, 1'b0); chk("cnt1_cleared", rd_data, 0);

        // Freeze with every event high
        for (int i = 0; i < 8; i++) saved[i] = m_cnt[i];
        freeze = 1'b1; set_events('1);
        repeat (20) tick();
        set_events('0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 1'b0);
            chk("freeze_hold", rd_data, saved[i][31:0]);
        end
        freeze = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            set_events(7'($urandom));
            freeze   = ($urandom_range(0, 9) == 0);
            clr_en   = ($urandom_range(0, 15) == 0);
            clr_mask = 8'($urandom);
            irq_mask = 8'($urandom);
            rd_en    = 1'($urandom);
            rd_sel   = 3'($urandom);
            rd_hi    = 1'($urandom);
            tick();
        end
        set_events('0); freeze = 0; clr_en = 0; rd_en = 0;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 1'b0);
            rd(3'(i), 1'b1);
        end

        // Reset asserted while a read is in flight
        rd_en = 1'b1; rd_sel = 3'd0; rd_hi = 1'b0;
        tick();
        chk("pre_rst_valid", rd_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_rd_data", rd_data, 0);
        chk("midrst_ovf", ovf, 0);
        model_reset();
        rd_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rd(3'd0, 1'b1); chk("hi_no_lo", rd_data, 0);
        rd(3'd0, 1'b0); chk("cnt0_post_rst", rd_data, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
